// File: rtl/sseg_display_driver_pkg.sv
// Shared types and default timing values for the multiplexed seven-segment driver.
package sseg_display_driver_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    localparam int DEFAULT_SLOT_CYCLES  = 100000;
    localparam int DEFAULT_GUARD_CYCLES = 16;
    localparam int DEFAULT_BLINK_FRAMES = 125;

    localparam logic [3:0] ANODES_OFF = 4'hF;
    localparam logic [7:0] SEGS_OFF   = 8'hFF;

endpackage

// File: rtl/sseg_display_driver_blink_timer.sv
// Counts frame latch loads and flips blink_phase once every BLINK_FRAMES loads.
module blink_timer
    import sseg_display_driver_pkg::*;
#(
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_load,
    output logic blink_phase
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_load) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/sseg_display_driver.sv
// Four-digit multiplexed seven-segment driver with guard blanking, PWM dimming,
// per-digit blinking and a per-frame input latch so a frame never tears.
module sseg_display_driver
    import sseg_display_driver_pkg::*;
#(
    parameter int SLOT_CYCLES  = DEFAULT_SLOT_CYCLES,
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sseg_in,
    input  logic [3:0]  blink_mask,
    input  logic [2:0]  bright,
    input  logic        disp_en,
    output logic [3:0]  anode,
    output logic [7:0]  sseg,
    output logic        frame_start
);

    localparam int ON_CYCLES = SLOT_CYCLES - GUARD_CYCLES;
    localparam int CW        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic [2:0]    pwm_cnt;
    logic [31:0]   sseg_lat;
    logic [3:0]    mask_lat;
    logic          loaded;
    logic          blink_phase;

    logic          slot_end;
    logic          frame_load;
    logic          digit_lit;
    logic [3:0]    anode_next;
    logic [7:0]    sseg_next;

    assign slot_end   = (state == ON) && (slot_cnt == ON_LAST);
    // The very first edge after reset also loads, so the display never shows reset junk
    assign frame_load = !loaded || (slot_end && (digit_idx == 2'd3));
    assign digit_lit  = (state == ON) && (pwm_cnt <= bright) && disp_en
                        && !(blink_phase && mask_lat[digit_idx]);

    always_comb begin
        anode_next = ANODES_OFF;
        sseg_next  = SEGS_OFF;
        if (digit_lit) begin
            anode_next = ~(4'b0001 << digit_idx);
            sseg_next  = sseg_lat[{digit_idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            slot_cnt    <= '0;
            digit_idx   <= 2'd0;
            anode       <= ANODES_OFF;
            sseg        <= SEGS_OFF;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_next;
            sseg        <= sseg_next;
            frame_start <= frame_load;
            case (state)
                BLANK: begin
                    if (slot_cnt == GUARD_LAST) begin
                        state    <= ON;
                        slot_cnt <= '0;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
                ON: begin
                    if (slot_end) begin
                        state     <= BLANK;
                        slot_cnt  <= '0;
                        digit_idx <= digit_idx + 2'd1;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= BLANK;
                    slot_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded   <= 1'b0;
            sseg_lat <= 32'hFFFF_FFFF;
            mask_lat <= 4'h0;
        end else if (frame_load) begin
            loaded   <= 1'b1;
            sseg_lat <= sseg_in;
            mask_lat <= blink_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 3'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_load (frame_load),
        .blink_phase(blink_phase)
    );

endmodule

// File: tb/tb_sseg_display_driver.sv
// Randomized bench for sseg_display_driver against a cycle-index arithmetic model.
module tb_sseg_display_driver;

    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst;
    logic [31:0] sseg_in;
    logic [3:0]  blink_mask;
    logic [2:0]  bright;
    logic        disp_en;
    logic [3:0]  anode;
    logic [7:0]  sseg;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Model state: k = cycle index since reset release, plus the latched frame it displays
    int          k       = 0;
    logic [31:0] m_lat   = 32'hFFFF_FFFF;
    logic [3:0]  m_mask  = 4'h0;
    int          m_loads = 0;

    sseg_display_driver #(
        .SLOT_CYCLES (SLOT),
        .GUARD_CYCLES(GUARD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sseg_in    (sseg_in),
        .blink_mask (blink_mask),
        .bright     (bright),
        .disp_en    (disp_en),
        .anode      (anode),
        .sseg       (sseg),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [3:0] m,
                                 input logic [2:0] b, input logic en);
        sseg_in    = s;
        blink_mask = m;
        bright     = b;
        disp_en    = en;
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        logic [3:0] ea;
        logic [7:0] es;
        logic       efs;
        int         pos;
        int         dig;
        int         pwm;
        bit         phase;
        bit         lit;
        if (rst) begin
            ea = 4'hF; es = 8'hFF; efs = 1'b0;
            k = 0; m_lat = 32'hFFFF_FFFF; m_mask = 4'h0; m_loads = 0;
        end else begin
            pos   = k % SLOT;
            dig   = (k / SLOT) % 4;
            pwm   = k % 8;
            phase = ((m_loads / BF) % 2) == 1;
            lit   = (pos >= GUARD) && (pwm <= int'(bright)) && disp_en
                    && !(phase && m_mask[dig]);
            ea    = lit ? ~(4'b0001 << dig) : 4'hF;
            es    = lit ? m_lat[8*dig +: 8] : 8'hFF;
            efs   = (k == 0) || (((k + 1) % FRAME) == 0);
            if (efs) begin
                m_lat  = sseg_in;
                m_mask = blink_mask;
                m_loads++;
            end
            k++;
        end
        #1;
        checkOutput("model_anode", anode, ea);
        checkOutput("model_sseg", sseg, es);
        checkOutput("model_frame_start", frame_start, efs);
    end

    initial begin
        int lit_count;
        rst = 1'b1;
        applyStimulus(32'h1122_3344, 4'h0, 3'd7, 1'b1);
        stepEdges(3);
        checkOutput("reset_anode", anode, 4'hF);
        checkOutput("reset_sseg", sseg, 8'hFF);
        checkOutput("reset_frame_start", frame_start, 1'b0);
        #2 rst = 1'b0;

        stepEdges(1);
        checkOutput("first_frame_start", frame_start, 1'b1);
        checkOutput("first_guard_anode", anode, 4'hF);
        stepEdges(2);
        checkOutput("digit0_anode", anode, 4'hE);
        checkOutput("digit0_sseg", sseg, 8'h44);
        stepEdges(8);
        checkOutput("digit1_anode", anode, 4'hD);
        checkOutput("digit1_sseg", sseg, 8'h33);
        #2 applyStimulus(32'hAABB_CCDD, 4'h0, 3'd7, 1'b1);
        stepEdges(8);
        checkOutput("digit2_old_anode", anode, 4'hB);
        checkOutput("digit2_old_sseg", sseg, 8'h22);
        stepEdges(8);
        checkOutput("digit3_old_anode", anode, 4'h7);
        checkOutput("digit3_old_sseg", sseg, 8'h11);
        stepEdges(5);
        checkOutput("second_frame_start", frame_start, 1'b1);
        stepEdges(3);
        checkOutput("digit0_new_sseg", sseg, 8'hDD);

        stepEdges(18);
        checkOutput("mid_digit2_anode", anode, 4'hB);
        checkOutput("mid_digit2_sseg", sseg, 8'hBB);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_anode", anode, 4'hF);
        checkOutput("async_reset_sseg", sseg, 8'hFF);
        stepEdges(1);
        #2 rst = 1'b0;
        stepEdges(1);
        checkOutput("rerelease_frame_start", frame_start, 1'b1);
        checkOutput("rerelease_guard_anode", anode, 4'hF);
        stepEdges(2);
        checkOutput("rerelease_digit0_anode", anode, 4'hE);
        checkOutput("rerelease_digit0_sseg", sseg, 8'hDD);

        #2 disp_en = 1'b0;
        lit_count = 0;
        for (int i = 0; i < 10; i++) begin
            stepEdges(1);
            if (anode !== 4'hF) lit_count++;
        end
        checkOutput("disp_en_dark_count", lit_count, 0);
        #2 disp_en = 1'b1;
        stepEdges(18);
        checkOutput("disp_en_no_early_frame", frame_start, 1'b0);
        stepEdges(1);
        checkOutput("disp_en_frame_start", frame_start, 1'b1);

        // Slot and PWM periods are both 8 here, so ON always spans PWM phases 2..7
        #2 bright = 3'd3;
        lit_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            stepEdges(1);
            if (anode !== 4'hF) lit_count++;
        end
        checkOutput("bright3_lit_count", lit_count, 8);
        #2 bright = 3'd0;
        lit_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            stepEdges(1);
            if (anode !== 4'hF) lit_count++;
        end
        checkOutput("bright0_lit_count", lit_count, 0);

        #2 applyStimulus(32'h1122_3344, 4'b0100, 3'd7, 1'b1);
        stepEdges(8 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            stepEdges(1);
            #2;
            if ($urandom_range(0, 15) == 0)
                applyStimulus($urandom, 4'($urandom_range(0, 15)),
                              3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 7) == 0)
                bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                stepEdges(1);
                #2 rst = 1'b0;
            end
        end

        stepEdges(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
